// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, decode valid/ready output, redirect and halt controls.
// The master side is the fetch unit; the slave side is the ROM plus decode/branch logic.
interface fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 49
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halt_req;
    logic              halted;

    modport master (
        output rom_addr,
        input  rom_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_en,
        input  redirect_addr,
        input  halt_req,
        output halted
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_en,
        output redirect_addr,
        input  halt_req,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, hides the ROM's 1-cycle read, 2 edges reset-to-first-valid, 1 instr/cycle.
// Stalls hold every register and re-read the pending address; redirect overrides stall and halt.
module fetch_unit #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 49,
    parameter int RESET_PC = 0
) (
    input logic          clka,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;
    logic              advance;

    assign advance = !instr_valid || bus.instr_ready;

    // A stalled cycle re-reads pend_pc so rom_data still matches it when the stall releases.
    always_comb begin
        bus.rom_addr = advance ? pc : pend_pc;
        if (rst)
            bus.rom_addr = RST_PC;
        else if (bus.redirect_en)
            bus.rom_addr = bus.redirect_addr;
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RST_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= RST_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (bus.redirect_en) begin
            // Output word and in-flight read both belong to the abandoned path.
            state       <= RUN;
            halted      <= 1'b0;
            instr_valid <= 1'b0;
            pend_valid  <= 1'b1;
            pend_pc     <= bus.redirect_addr;
            pc          <= bus.redirect_addr + 1'b1;
        end else if (advance) begin
            if (state == HALT) begin
                instr_valid <= 1'b0;
            end else begin
                if (pend_valid) begin
                    instr       <= bus.rom_data;
                    instr_pc    <= pend_pc;
                    instr_valid <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                end
                if (bus.halt_req) begin
                    pend_valid <= 1'b0;
                    state      <= HALT;
                    halted     <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_pc    <= pc;
                    pc         <= pc + 1'b1;
                end
            end
        end
    end

    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = instr_valid;
    assign bus.halted      = halted;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural ROM with ROM[i]=i, vector table plus hand sequences.
module tb_fetch_unit;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 49;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    logic [DATA_W-1:0] rom_mem [16];
    always @(posedge clka) bus.rom_data <= rom_mem[bus.rom_addr];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       re;
        logic [3:0] ra;
        logic       hq;
        logic [3:0] exp_addr;
        logic       exp_v;
        logic [3:0] exp_pc;
        logic       exp_h;
    } vec_t;

    vec_t vt [34];

    function automatic vec_t mk(input logic r, input logic rdy, input logic re, input int ra,
                                input logic hq, input int ea, input logic ev, input int ep,
                                input logic eh);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.re = re; v.ra = 4'(ra); v.hq = hq;
        v.exp_addr = 4'(ea); v.exp_v = ev; v.exp_pc = 4'(ep); v.exp_h = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic re, input logic [3:0] ra,
                         input logic hq);
        rst = r;
        bus.instr_ready = rdy;
        bus.redirect_en = re;
        bus.redirect_addr = ra;
        bus.halt_req = hq;
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Output is valid and carries instruction/pc p.
    task automatic chk_out(input string nm, input int p);
        chk({nm, "_valid"}, 64'(bus.instr_valid), 64'd1);
        chk({nm, "_pc"}, 64'(bus.instr_pc), 64'(p));
        chk({nm, "_instr"}, 64'(bus.instr), 64'(p));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
        chk({nm, "_valid"}, 64'(bus.instr_valid), 64'd0);
        chk({nm, "_instr"}, 64'(bus.instr), 64'd0);
        chk({nm, "_pc"}, 64'(bus.instr_pc), 64'd0);
        chk({nm, "_halted"}, 64'(bus.halted), 64'd0);
    endtask

    // From reset: first edge gives nothing, then 0..15,0,1 one per cycle.
    task automatic run_from_reset(input string nm);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        #1;
        chk({nm, "_addr_e0"}, 64'(bus.rom_addr), 64'd0);
        tick();
        chk({nm, "_valid_e0"}, 64'(bus.instr_valid), 64'd0);
        for (int n = 0; n < 18; n++) begin
            chk($sformatf("%s_addr%0d", nm, n), 64'(bus.rom_addr), 64'((n + 1) % 16));
            tick();
            chk_out($sformatf("%s_seq%0d", nm, n), n % 16);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = DATA_W'(i);

        // rdy, re, ra, hq, exp rom_addr before edge, exp valid/pc/halted after edge
        vt[0]  = mk(0, 1, 0,  0, 0,  3, 1,  2, 0);
        vt[1]  = mk(0, 1, 0,  0, 0,  4, 1,  3, 0);
        vt[2]  = mk(0, 1, 0,  0, 0,  5, 1,  4, 0);
        vt[3]  = mk(0, 1, 0,  0, 0,  6, 1,  5, 0);
        vt[4]  = mk(0, 0, 0,  0, 0,  6, 1,  5, 0);
        vt[5]  = mk(0, 0, 0,  0, 0,  6, 1,  5, 0);
        vt[6]  = mk(0, 0, 0,  0, 0,  6, 1,  5, 0);
        vt[7]  = mk(0, 1, 0,  0, 0,  7, 1,  6, 0);
        vt[8]  = mk(0, 1, 0,  0, 0,  8, 1,  7, 0);
        vt[9]  = mk(0, 1, 1,  2, 0,  2, 0,  0, 0);
        vt[10] = mk(0, 1, 0,  0, 0,  3, 1,  2, 0);
        vt[11] = mk(0, 1, 0,  0, 0,  4, 1,  3, 0);
        vt[12] = mk(0, 1, 1,  9, 0,  9, 0,  0, 0);
        vt[13] = mk(0, 1, 0,  0, 0, 10, 1,  9, 0);
        vt[14] = mk(0, 1, 0,  0, 0, 11, 1, 10, 0);
        vt[15] = mk(0, 1, 0,  0, 1, 12, 1, 11, 1);
        vt[16] = mk(0, 1, 0,  0, 0, 12, 0,  0, 1);
        vt[17] = mk(0, 1, 0,  0, 0, 12, 0,  0, 1);
        vt[18] = mk(0, 1, 0,  0, 1, 12, 0,  0, 1);
        vt[19] = mk(0, 1, 1,  0, 0,  0, 0,  0, 0);
        vt[20] = mk(0, 1, 0,  0, 0,  1, 1,  0, 0);
        vt[21] = mk(0, 1, 0,  0, 0,  2, 1,  1, 0);
        vt[22] = mk(0, 0, 0,  0, 1,  2, 1,  1, 0);
        vt[23] = mk(0, 1, 0,  0, 0,  3, 1,  2, 0);
        vt[24] = mk(0, 1, 0,  0, 0,  4, 1,  3, 0);
        vt[25] = mk(0, 1, 0,  0, 0,  5, 1,  4, 0);
        vt[26] = mk(0, 1, 0,  0, 0,  6, 1,  5, 0);
        vt[27] = mk(0, 1, 0,  0, 0,  7, 1,  6, 0);
        vt[28] = mk(0, 1, 0,  0, 0,  8, 1,  7, 0);
        vt[29] = mk(0, 0, 0,  0, 0,  8, 1,  7, 0);
        vt[30] = mk(0, 0, 1, 14, 0, 14, 0,  0, 0);
        vt[31] = mk(0, 0, 0,  0, 0, 15, 1, 14, 0);
        vt[32] = mk(0, 1, 0,  0, 0,  0, 1, 15, 0);
        vt[33] = mk(0, 1, 0,  0, 0,  1, 1,  0, 0);

        // Reset state
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        chk_reset("reset");

        run_from_reset("boot");

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].rdy, vt[i].re, vt[i].ra, vt[i].hq);
            #1;
            chk($sformatf("v%0d_rom_addr", i), 64'(bus.rom_addr), 64'(vt[i].exp_addr));
            tick();
            chk($sformatf("v%0d_valid", i), 64'(bus.instr_valid), 64'(vt[i].exp_v));
            chk($sformatf("v%0d_halted", i), 64'(bus.halted), 64'(vt[i].exp_h));
            if (vt[i].exp_v) begin
                chk($sformatf("v%0d_pc", i), 64'(bus.instr_pc), 64'(vt[i].exp_pc));
                chk($sformatf("v%0d_instr", i), 64'(bus.instr), 64'(vt[i].exp_pc));
            end
        end

        // Reset in the middle of a stall at instr_pc=12
        drive(1'b0, 1'b1, 1'b1, 4'd11, 1'b0);
        tick();
        chk("r6_flush_valid", 64'(bus.instr_valid), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("r6_pc11", 11);
        tick();
        chk_out("r6_pc12", 12);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("r6_stall", 12);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        chk("r6_rst_addr", 64'(bus.rom_addr), 64'd0);
        tick();
        chk_reset("r6_after_rst");

        run_from_reset("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
